// File: rtl/serial_operand_demux_if.sv
// Serial operand link plus parallel operand-pair handshake.
// slave = the demux, master = serial source / adder side.
interface serial_operand_demux_if #(parameter int WIDTH = 8);
  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic             frame_start;
  logic [WIDTH-1:0] dout_0;
  logic [WIDTH-1:0] dout_1;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             par_err;

  modport slave (
    input  ser_in, ser_valid, frame_start, dout_ready,
    output ser_ready, dout_0, dout_1, dout_valid, frame_err, par_err
  );

  modport master (
    output ser_in, ser_valid, frame_start, dout_ready,
    input  ser_ready, dout_0, dout_1, dout_valid, frame_err, par_err
  );
endinterface

// File: rtl/serial_operand_demux.sv
// LSB-first serial stream -> operand pair (A then B) with valid/ready output.
// Optional per-operand even parity bit: define DEMUX_PARITY_EN.
module serial_operand_demux #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_operand_demux_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_0 = 3'd1;
  localparam logic [2:0] S_LOAD_1 = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
`ifdef DEMUX_PARITY_EN
  localparam logic [2:0] S_PAR_0  = 3'd4;
  localparam logic [2:0] S_PAR_1  = 3'd5;
`endif

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh_a, r_sh_b;
  logic [WIDTH-1:0] r_dout_0, r_dout_1;
  logic             r_dout_valid, r_frame_err;
  logic             w_ser_ready, w_acc;
  logic [WIDTH-1:0] w_b_next;
`ifdef DEMUX_PARITY_EN
  logic             r_par_bad, r_par_err;
`endif

  assign w_ser_ready = (r_state != S_HOLD);
  assign w_acc       = bus.ser_valid && w_ser_ready;

  // B including the bit landing this cycle, so HOLD can load it on the same edge
  always_comb begin
    w_b_next        = r_sh_b;
    w_b_next[r_cnt] = bus.ser_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sh_a       <= '0;
      r_sh_b       <= '0;
      r_dout_0     <= '0;
      r_dout_1     <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef DEMUX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc && bus.frame_start) begin
            r_sh_a[0] <= bus.ser_in;
            r_cnt     <= CW'(1);
            r_state   <= S_LOAD_0;
`ifdef DEMUX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
          end
        end
        S_HOLD: begin
          if (bus.dout_ready) begin
            r_dout_valid <= 1'b0;
            r_state      <= S_IDLE;
`ifdef DEMUX_PARITY_EN
            r_par_err    <= 1'b0;
`endif
          end
        end
        default: begin
          if (w_acc) begin
            if (bus.frame_start) begin
              // abort: this bit restarts a fresh frame as A bit 0
              r_frame_err <= 1'b1;
              r_sh_a[0]   <= bus.ser_in;
              r_cnt       <= CW'(1);
              r_state     <= S_LOAD_0;
`ifdef DEMUX_PARITY_EN
              r_par_bad   <= 1'b0;
`endif
            end else begin
              case (r_state)
                S_LOAD_0: begin
                  r_sh_a[r_cnt] <= bus.ser_in;
                  if (r_cnt == LAST) begin
                    r_cnt <= '0;
`ifdef DEMUX_PARITY_EN
                    r_state <= S_PAR_0;
`else
                    r_state <= S_LOAD_1;
`endif
                  end else begin
                    r_cnt <= r_cnt + CW'(1);
                  end
                end
                S_LOAD_1: begin
                  r_sh_b[r_cnt] <= bus.ser_in;
                  if (r_cnt == LAST) begin
                    r_cnt <= '0;
`ifdef DEMUX_PARITY_EN
                    r_state <= S_PAR_1;
`else
                    r_state      <= S_HOLD;
                    r_dout_0     <= r_sh_a;
                    r_dout_1     <= w_b_next;
                    r_dout_valid <= 1'b1;
`endif
                  end else begin
                    r_cnt <= r_cnt + CW'(1);
                  end
                end
`ifdef DEMUX_PARITY_EN
                S_PAR_0: begin
                  r_par_bad <= (^r_sh_a) ^ bus.ser_in;
                  r_state   <= S_LOAD_1;
                end
                S_PAR_1: begin
                  r_par_err    <= r_par_bad | ((^r_sh_b) ^ bus.ser_in);
                  r_state      <= S_HOLD;
                  r_dout_0     <= r_sh_a;
                  r_dout_1     <= r_sh_b;
                  r_dout_valid <= 1'b1;
                end
`endif
                default: r_state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.ser_ready  = w_ser_ready;
  assign bus.dout_0     = r_dout_0;
  assign bus.dout_1     = r_dout_1;
  assign bus.dout_valid = r_dout_valid;
  assign bus.frame_err  = r_frame_err;
`ifdef DEMUX_PARITY_EN
  assign bus.par_err    = r_par_err;
`else
  assign bus.par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_operand_demux.sv
// Directed bench for serial_operand_demux: bit-queue frame model checked every
// cycle, plus literal expectations per scenario.
module tb_serial_operand_demux;
  localparam int W = 8;
`ifdef DEMUX_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = 2*W + 2;
  localparam int BOFF  = W + 1;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = 2*W;
  localparam int BOFF  = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0, n_fail = 0, ferr_seen = 0;

  serial_operand_demux_if #(.WIDTH(W)) bus();
  serial_operand_demux #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model: collect accepted bits of the current frame; a full frame yields the pair.
  bit         m_dv, m_ferr, m_perr, m_inf;
  logic [W-1:0] m_d0, m_d1;
  bit         m_q[$];

  initial begin
    m_dv = 0; m_ferr = 0; m_perr = 0; m_inf = 0; m_d0 = '0; m_d1 = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_dv = 0; m_ferr = 0; m_perr = 0; m_inf = 0; m_d0 = '0; m_d1 = '0;
        m_q.delete();
      end else begin
        m_ferr = 0;
        if (m_dv) begin
          if (bus.dout_ready) begin m_dv = 0; m_perr = 0; end
        end else if (bus.ser_valid) begin
          if (bus.frame_start) begin
            m_ferr = m_inf;
            m_q.delete();
            m_q.push_back(bus.ser_in);
            m_inf = 1;
          end else if (m_inf) begin
            m_q.push_back(bus.ser_in);
          end
          if (m_inf && m_q.size() == FRAME) begin
            for (int i = 0; i < W; i++) begin
              m_d0[i] = m_q[i];
              m_d1[i] = m_q[BOFF+i];
            end
            if (PAR) m_perr = ((^m_d0) != m_q[W]) || ((^m_d1) != m_q[BOFF+W]);
            m_dv = 1; m_inf = 0;
            m_q.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    n_tests++;
    if (bus.ser_ready !== !m_dv || bus.dout_valid !== m_dv || bus.dout_0 !== m_d0 ||
        bus.dout_1 !== m_d1 || bus.frame_err !== m_ferr || bus.par_err !== m_perr) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: got rdy=%b dv=%b d0=%h d1=%h ferr=%b perr=%b, want rdy=%b dv=%b d0=%h d1=%h ferr=%b perr=%b",
               $time, bus.ser_ready, bus.dout_valid, bus.dout_0, bus.dout_1, bus.frame_err, bus.par_err,
               !m_dv, m_dv, m_d0, m_d1, m_ferr, m_perr);
    end
    if (bus.frame_err === 1'b1) ferr_seen++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_bit(input logic b, input logic fs, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) begin bus.ser_valid = 1'b0; tick(); end
    bus.ser_valid = 1'b1; bus.ser_in = b; bus.frame_start = fs;
    tick();
    bus.ser_valid = 1'b0; bus.frame_start = 1'b0;
  endtask

  task automatic send_op(input logic [W-1:0] v, input bit first, input bit gaps, input bit pflip);
    for (int i = 0; i < W; i++) drive_bit(v[i], first && i == 0, gaps);
    if (PAR) drive_bit((^v) ^ pflip, 1'b0, gaps);
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit gaps, input bit bflip);
    send_op(a, 1'b1, gaps, 1'b0);
    send_op(b, 1'b0, gaps, bflip);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, bus.ser_ready, 1);
    chk({nm, "_dv"},  bus.dout_valid, 0);
    chk({nm, "_d0"},  bus.dout_0, 0);
    chk({nm, "_d1"},  bus.dout_1, 0);
    chk({nm, "_perr"}, bus.par_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bus.ser_valid = 1'b0; bus.ser_in = 1'b0; bus.frame_start = 1'b0; bus.dout_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    chk_zero("reset");
    rst = 1'b0;

    // basic frame
    send_frame(8'hA5, 8'h3C, 1'b0, 1'b0);
    chk("basic_dv", bus.dout_valid, 1);
    chk("basic_d0", bus.dout_0, 8'hA5);
    chk("basic_d1", bus.dout_1, 8'h3C);
    tick();
    chk("basic_dv_drop", bus.dout_valid, 0);
    chk("basic_d0_keep", bus.dout_0, 8'hA5);

    // backpressure
    bus.dout_ready = 1'b0;
    send_frame(8'hFF, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.ser_valid = 1'b1; bus.ser_in = 1'b0; bus.frame_start = i[0];
      tick();
      chk("bp_rdy", bus.ser_ready, 0);
      chk("bp_dv", bus.dout_valid, 1);
    end
    bus.ser_valid = 1'b0; bus.frame_start = 1'b0; bus.dout_ready = 1'b1;
    chk("bp_d0", bus.dout_0, 8'hFF);
    chk("bp_d1", bus.dout_1, 8'h01);
    tick();
    chk("bp_release_dv", bus.dout_valid, 0);
    chk("bp_release_rdy", bus.ser_ready, 1);

    // stray bits then gapped frame
    repeat (3) drive_bit(1'b1, 1'b0, 1'b0);
    chk("stray_dv", bus.dout_valid, 0);
    send_frame(8'h12, 8'h34, 1'b1, 1'b0);
    chk("gap_dv", bus.dout_valid, 1);
    chk("gap_d0", bus.dout_0, 8'h12);
    chk("gap_d1", bus.dout_1, 8'h34);
    tick();

    // abort at bit 11, then full frame
    f0 = ferr_seen;
    send_op(8'h99, 1'b1, 1'b0, 1'b0);
    repeat (11 - W - (PAR ? 1 : 0)) drive_bit(1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 8'hAA, 1'b0, 1'b0);
    chk("abort_ferr_count", ferr_seen - f0, 1);
    chk("abort_d0", bus.dout_0, 8'h55);
    chk("abort_d1", bus.dout_1, 8'hAA);
    tick();

    // reset at bit 5
    for (int i = 0; i < 5; i++) drive_bit(1'b1, i == 0, 1'b0);
    bus.ser_valid = 1'b1; bus.ser_in = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; bus.ser_valid = 1'b0;
    chk_zero("rst_mid");
    send_frame(8'h5A, 8'hC3, 1'b0, 1'b0);
    chk("rst_mid_d0", bus.dout_0, 8'h5A);
    chk("rst_mid_d1", bus.dout_1, 8'hC3);
    tick();

    // reset while holding
    bus.dout_ready = 1'b0;
    send_frame(8'h0F, 8'hF0, 1'b0, 1'b0);
    chk("hold_dv", bus.dout_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_hold");
    bus.dout_ready = 1'b1;
    send_frame(8'h81, 8'h7E, 1'b0, 1'b0);
    chk("rst_hold_d0", bus.dout_0, 8'h81);
    chk("rst_hold_d1", bus.dout_1, 8'h7E);
    tick();

`ifdef DEMUX_PARITY_EN
    send_frame(8'h03, 8'h07, 1'b0, 1'b0);
    chk("par_ok_dv", bus.dout_valid, 1);
    chk("par_ok_perr", bus.par_err, 0);
    tick();
    send_frame(8'h03, 8'h07, 1'b0, 1'b1);
    chk("par_bad_perr", bus.par_err, 1);
    chk("par_bad_d0", bus.dout_0, 8'h03);
    chk("par_bad_d1", bus.dout_1, 8'h07);
    tick();
    chk("par_clear", bus.par_err, 0);
`else
    send_frame(8'h03, 8'h07, 1'b0, 1'b0);
    chk("nopar_perr", bus.par_err, 0);
    chk("nopar_d1", bus.dout_1, 8'h07);
    tick();
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
